// File: rtl/sign_extend_8_to_16_if.sv
// Operand/result bundle for sign_extend_8_to_16.
// neg_count exists only when SIGN_EXT_STATS_EN is defined.
interface sign_extend_8_to_16_if;
   logic [7:0]  i_in;
   logic [1:0]  i_mode;
   logic        i_in_valid;
   logic [15:0] o_out;
   logic [15:0] o_out_q;
   logic        o_out_valid;
   logic        o_neg_q;
   logic        o_zero_q;
`ifdef SIGN_EXT_STATS_EN
   logic [15:0] o_neg_count;
`endif

`ifdef SIGN_EXT_STATS_EN
   modport master (
      output i_in, i_mode, i_in_valid,
      input  o_out, o_out_q, o_out_valid, o_neg_q, o_zero_q, o_neg_count
   );
   modport slave (
      input  i_in, i_mode, i_in_valid,
      output o_out, o_out_q, o_out_valid, o_neg_q, o_zero_q, o_neg_count
   );
`else
   modport master (
      output i_in, i_mode, i_in_valid,
      input  o_out, o_out_q, o_out_valid, o_neg_q, o_zero_q
   );
   modport slave (
      input  i_in, i_mode, i_in_valid,
      output o_out, o_out_q, o_out_valid, o_neg_q, o_zero_q
   );
`endif
endinterface

// File: rtl/sign_extend_8_to_16.sv
// Widens a byte to 16 bits (sign/zero/high-byte), combinationally and via a 1-cycle register.
// Defining SIGN_EXT_STATS_EN adds a wrapping count of captures with a negative result.
module sign_extend_8_to_16 (
   input  logic                     clk,
   input  logic                     rst,
   sign_extend_8_to_16_if.slave     bus
);

   logic [15:0] w_out;
   logic [15:0] r_out_q;
   logic        r_out_valid;
   logic        r_neg_q;
   logic        r_zero_q;

   // Unknown or 2'b11 modes fall into the sign-extend default.
   always_comb begin
      w_out = {{8{bus.i_in[7]}}, bus.i_in};
      case (bus.i_mode)
         2'b01:   w_out = {8'h00, bus.i_in};
         2'b10:   w_out = {bus.i_in, 8'h00};
         default: w_out = {{8{bus.i_in[7]}}, bus.i_in};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_q     <= 16'h0000;
         r_out_valid <= 1'b0;
         r_neg_q     <= 1'b0;
         r_zero_q    <= 1'b1;
      end else begin
         r_out_valid <= bus.i_in_valid;
         if (bus.i_in_valid) begin
            r_out_q  <= w_out;
            r_neg_q  <= w_out[15];
            r_zero_q <= (w_out == 16'h0000);
         end
      end
   end

`ifdef SIGN_EXT_STATS_EN
   logic [15:0] r_neg_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_neg_count <= 16'h0000;
      else if (bus.i_in_valid && w_out[15])
         r_neg_count <= r_neg_count + 16'h0001;
   end

   assign bus.o_neg_count = r_neg_count;
`endif

   assign bus.o_out       = w_out;
   assign bus.o_out_q     = r_out_q;
   assign bus.o_out_valid = r_out_valid;
   assign bus.o_neg_q     = r_neg_q;
   assign bus.o_zero_q    = r_zero_q;

endmodule

// File: tb/tb_sign_extend_8_to_16.sv
// Directed-vector bench for sign_extend_8_to_16; builds with or without SIGN_EXT_STATS_EN.
module tb_sign_extend_8_to_16;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   sign_extend_8_to_16_if bus ();

   sign_extend_8_to_16 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      bus.i_in = 8'h00; bus.i_mode = 2'b00; bus.i_in_valid = 1'b0;
      #3;
      n_checks++;
      if (bus.o_out_q !== 16'h0000) begin n_fail++; $display("FAIL reset_out_q got=%h exp=0000", bus.o_out_q); end
      n_checks++;
      if (bus.o_zero_q !== 1'b1) begin n_fail++; $display("FAIL reset_zero_q got=%b exp=1", bus.o_zero_q); end
      n_checks++;
      if (bus.o_neg_q !== 1'b0 || bus.o_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_neg_valid got=%b%b exp=00", bus.o_neg_q, bus.o_out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_comb();
      logic [7:0]  v_in   [6] = '{8'h55, 8'hAA, 8'hAA, 8'h80, 8'h00, 8'h81};
      logic [1:0]  v_mode [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
      logic [15:0] v_exp  [6] = '{16'h0055, 16'hFFAA, 16'h00AA, 16'h8000, 16'h0000, 16'hFF81};
      for (int i = 0; i < 6; i++) begin
         bus.i_in = v_in[i]; bus.i_mode = v_mode[i];
         #1;
         n_checks++;
         if (bus.o_out !== v_exp[i]) begin
            n_fail++; $display("FAIL comb_%0d got=%h exp=%h", i, bus.o_out, v_exp[i]);
         end
      end
   endtask

   task automatic test_capture();
      @(negedge clk);
      bus.i_in = 8'hFF; bus.i_mode = 2'b00; bus.i_in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.o_out_q !== 16'hFFFF || bus.o_neg_q !== 1'b1 || bus.o_zero_q !== 1'b0 || bus.o_out_valid !== 1'b1) begin
         n_fail++; $display("FAIL capture_ff got=%h n%b z%b v%b exp=ffff n1 z0 v1",
                            bus.o_out_q, bus.o_neg_q, bus.o_zero_q, bus.o_out_valid);
      end
      @(negedge clk);
      bus.i_in_valid = 1'b0; bus.i_in = 8'h12;
      @(posedge clk); #1;
      n_checks++;
      if (bus.o_out_q !== 16'hFFFF || bus.o_out_valid !== 1'b0 || bus.o_neg_q !== 1'b1) begin
         n_fail++; $display("FAIL capture_hold got=%h v%b n%b exp=ffff v0 n1", bus.o_out_q, bus.o_out_valid, bus.o_neg_q);
      end
      @(negedge clk);
      bus.i_in = 8'h00; bus.i_mode = 2'b10; bus.i_in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.o_out_q !== 16'h0000 || bus.o_zero_q !== 1'b1 || bus.o_neg_q !== 1'b0) begin
         n_fail++; $display("FAIL capture_zero got=%h z%b n%b exp=0000 z1 n0", bus.o_out_q, bus.o_zero_q, bus.o_neg_q);
      end
      @(negedge clk);
      bus.i_in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  v_in   [3] = '{8'h80, 8'h7F, 8'h01};
      logic [1:0]  v_mode [3] = '{2'b01, 2'b10, 2'b11};
      logic [15:0] v_exp  [3] = '{16'h0080, 16'h7F00, 16'h0001};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.i_in = v_in[i]; bus.i_mode = v_mode[i]; bus.i_in_valid = 1'b1;
         @(posedge clk); #1;
         n_checks++;
         if (bus.o_out_q !== v_exp[i] || bus.o_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_%0d got=%h v%b exp=%h v1", i, bus.o_out_q, bus.o_out_valid, v_exp[i]);
         end
      end
      @(negedge clk);
      bus.i_in_valid = 1'b0;
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      bus.i_in = 8'hC3; bus.i_mode = 2'b00; bus.i_in_valid = 1'b1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.o_out_q !== 16'h0000 || bus.o_zero_q !== 1'b1 || bus.o_out_valid !== 1'b0 || bus.o_neg_q !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid got=%h z%b v%b n%b exp=0000 z1 v0 n0",
                            bus.o_out_q, bus.o_zero_q, bus.o_out_valid, bus.o_neg_q);
      end
      bus.i_in = 8'h90;
      #1;
      n_checks++;
      if (bus.o_out !== 16'hFF90) begin n_fail++; $display("FAIL rst_comb got=%h exp=ff90", bus.o_out); end
      @(negedge clk);
      rst = 1'b0;
      bus.i_in = 8'h05; bus.i_mode = 2'b01;
      @(posedge clk); #1;
      n_checks++;
      if (bus.o_out_q !== 16'h0005 || bus.o_out_valid !== 1'b1 || bus.o_zero_q !== 1'b0) begin
         n_fail++; $display("FAIL rst_release got=%h v%b z%b exp=0005 v1 z0", bus.o_out_q, bus.o_out_valid, bus.o_zero_q);
      end
      @(negedge clk);
      bus.i_in_valid = 1'b0;
   endtask

`ifdef SIGN_EXT_STATS_EN
   task automatic test_stats();
      logic [7:0] v_in [5] = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.i_in = v_in[i]; bus.i_mode = 2'b00; bus.i_in_valid = 1'b1;
         @(negedge clk);
      end
      bus.i_in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_neg_count !== 16'd3) begin n_fail++; $display("FAIL stats_count got=%0d exp=3", bus.o_neg_count); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.o_neg_count !== 16'd0) begin n_fail++; $display("FAIL stats_rst got=%0d exp=0", bus.o_neg_count); end
      @(negedge clk);
      rst = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_comb();
      test_capture();
      test_back_to_back();
      test_rst_mid();
`ifdef SIGN_EXT_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
